// File: rtl/qbert_motion_ctrl.sv
// Q*bert sprite position controller: accepts jump commands, walks the
// sprite centre pixel by pixel to the target cube at a divided tick rate.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   x_init, y_init      start position, loaded on reset and on load
//   load                in IDLE, forces position to x_init/y_init
//   jump_req, jump_dir  single-cycle jump request and direction
//                       (bit0: 0=x+DX 1=x-DX, bit1: 0=y-DY 1=y+DY)
//   jump_ack, jump_err  1-cycle accept / out-of-bounds reject pulses
//   busy, done          move in progress / 1-cycle completion pulse
//   qbert_x, qbert_y    current sprite centre
module qbert_motion_ctrl #(
    parameter int DX        = 60,
    parameter int DY        = 50,
    parameter int TICK_LOG2 = 20,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 799,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x_init,
    input  logic [9:0]  y_init,
    input  logic        load,
    input  logic        jump_req,
    input  logic [1:0]  jump_dir,
    output logic        jump_ack,
    output logic        jump_err,
    output logic        busy,
    output logic        done,
    output logic [10:0] qbert_x,
    output logic [9:0]  qbert_y
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE1,
        MOVE2,
        FINISH
    } state_t;

    localparam int CW = TICK_LOG2 + 1;
    localparam logic [CW-1:0] TICK_AT = CW'(1) << TICK_LOG2;

    localparam logic signed [11:0] SDX = 12'(DX);
    localparam logic signed [11:0] SDY = 12'(DY);
    localparam logic signed [11:0] XLO = 12'(X_MIN);
    localparam logic signed [11:0] XHI = 12'(X_MAX);
    localparam logic signed [11:0] YLO = 12'(Y_MIN);
    localparam logic signed [11:0] YHI = 12'(Y_MAX);

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic              tick;
    logic signed [11:0] cx, cy, tx, ty;
    logic              in_bounds;
    logic              idle, accept, reject;
    logic [10:0]       tgt_x;
    logic [9:0]        tgt_y;
    logic              down;
    logic              walk_x, walk_y;
    logic              at_x, at_y, arrived;

    // Free-running divider; tick marks the 0->1 edge of its top bit.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == TICK_AT);

    // Candidate target in signed arithmetic so underflow is visible.
    assign cx = signed'({1'b0, qbert_x});
    assign cy = signed'({2'b00, qbert_y});
    assign tx = jump_dir[0] ? cx - SDX : cx + SDX;
    assign ty = jump_dir[1] ? cy + SDY : cy - SDY;

    assign in_bounds = (tx >= XLO) && (tx <= XHI) &&
                       (ty >= YLO) && (ty <= YHI);

    // load takes priority over a simultaneous jump request.
    assign idle   = (state == IDLE);
    assign accept = idle && !load && jump_req && in_bounds;
    assign reject = idle && !load && jump_req && !in_bounds;

    // Up jumps walk y first; down jumps walk x first.
    assign walk_x = ((state == MOVE1) && down) ||
                    ((state == MOVE2) && !down);
    assign walk_y = ((state == MOVE1) && !down) ||
                    ((state == MOVE2) && down);

    assign at_x    = (qbert_x == tgt_x);
    assign at_y    = (qbert_y == tgt_y);
    assign arrived = walk_x ? at_x : at_y;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)  state_nxt = MOVE1;
            MOVE1:   if (arrived) state_nxt = MOVE2;
            MOVE2:   if (arrived) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qbert_x  <= x_init;
            qbert_y  <= y_init;
            tgt_x    <= x_init;
            tgt_y    <= y_init;
            down     <= 1'b0;
            jump_ack <= 1'b0;
            jump_err <= 1'b0;
        end else begin
            jump_ack <= accept;
            jump_err <= reject;
            if (idle) begin
                if (load) begin
                    qbert_x <= x_init;
                    qbert_y <= y_init;
                end else if (accept) begin
                    tgt_x <= tx[10:0];
                    tgt_y <= ty[9:0];
                    down  <= jump_dir[1];
                end
            end else if (tick) begin
                if (walk_x && !at_x)
                    qbert_x <= (qbert_x < tgt_x) ? qbert_x + 11'd1
                                                 : qbert_x - 11'd1;
                if (walk_y && !at_y)
                    qbert_y <= (qbert_y < tgt_y) ? qbert_y + 10'd1
                                                 : qbert_y - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_qbert_motion_ctrl.sv
// Self-checking bench for qbert_motion_ctrl: waypoint-queue model
// compared every cycle, plus directed literal checks.
module tb_qbert_motion_ctrl;

    localparam int TL   = 1;
    localparam int PDX  = 3;
    localparam int PDY  = 2;
    localparam int XMX  = 20;
    localparam int YMX  = 20;
    localparam int PER  = 1 << (TL + 1);
    localparam int HALF = 1 << TL;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_init;
    logic [9:0]  y_init;
    logic        load;
    logic        jump_req;
    logic [1:0]  jump_dir;
    logic        jump_ack;
    logic        jump_err;
    logic        busy;
    logic        done;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;

    qbert_motion_ctrl #(
        .DX(PDX), .DY(PDY), .TICK_LOG2(TL),
        .X_MIN(0), .X_MAX(XMX), .Y_MIN(0), .Y_MAX(YMX)
    ) dut (
        .clk(clk), .reset(reset),
        .x_init(x_init), .y_init(y_init),
        .load(load), .jump_req(jump_req), .jump_dir(jump_dir),
        .jump_ack(jump_ack), .jump_err(jump_err),
        .busy(busy), .done(done),
        .qbert_x(qbert_x), .qbert_y(qbert_y)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: position plus a queue of remaining waypoints, one per tick.
    int mx, my;
    int qx[$];
    int qy[$];
    bit mbusy, mfin, mack, merr, mvalid = 1'b0;
    int since;
    int ntx, nty;
    bit ntick;

    task automatic plan(input int tx, input int ty, input bit dn);
        int px, py;
        px = mx;
        py = my;
        for (int ph = 0; ph < 2; ph++) begin
            if ((ph == 0) != dn) begin
                while (py != ty) begin
                    py += (ty > py) ? 1 : -1;
                    qx.push_back(px);
                    qy.push_back(py);
                end
            end else begin
                while (px != tx) begin
                    px += (tx > px) ? 1 : -1;
                    qx.push_back(px);
                    qy.push_back(py);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mx = int'(x_init);
            my = int'(y_init);
            qx.delete();
            qy.delete();
            mbusy = 1'b0;
            mfin = 1'b0;
            mack = 1'b0;
            merr = 1'b0;
            since = 0;
            mvalid = 1'b1;
        end else begin
            ntick = ((since % PER) == HALF);
            mack = 1'b0;
            merr = 1'b0;
            if (!mbusy) begin
                if (load) begin
                    mx = int'(x_init);
                    my = int'(y_init);
                end else if (jump_req) begin
                    ntx = mx + (jump_dir[0] ? -PDX : PDX);
                    nty = my + (jump_dir[1] ? PDY : -PDY);
                    if (ntx >= 0 && ntx <= XMX && nty >= 0 && nty <= YMX) begin
                        plan(ntx, nty, jump_dir[1]);
                        mack = 1'b1;
                        mbusy = 1'b1;
                    end else begin
                        merr = 1'b1;
                    end
                end
            end else if (mfin) begin
                mfin = 1'b0;
                mbusy = 1'b0;
            end else if (qx.size() == 0) begin
                mfin = 1'b1;
            end else if (ntick) begin
                mx = qx.pop_front();
                my = qy.pop_front();
            end
            since++;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("cmp_x", int'(qbert_x), mx);
            chk("cmp_y", int'(qbert_y), my);
            chk("cmp_busy", int'(busy), int'(mbusy));
            chk("cmp_done", int'(done), int'(mfin));
            chk("cmp_ack", int'(jump_ack), int'(mack));
            chk("cmp_err", int'(jump_err), int'(merr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int start, output int at);
        int c;
        c = start;
        while (!done && c < start + 60) begin
            step();
            c++;
            @(negedge clk);
        end
        at = c;
    endtask

    task automatic jump(input logic [1:0] d);
        jump_dir = d;
        jump_req = 1'b1;
        step();
        jump_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input int x, input int y);
        x_init = 11'(x);
        y_init = 10'(y);
        load = 1'b1;
        step();
        load = 1'b0;
        @(negedge clk);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        x_init = 11'd10;
        y_init = 10'd10;
        load = 1'b0;
        jump_req = 1'b0;
        jump_dir = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_x", int'(qbert_x), 10);
        chk("rst_y", int'(qbert_y), 10);
        chk("rst_busy", int'(busy), 0);

        // Up-right jump from reset: first tick at cycle 2.
        jump(2'b00);
        chk("s1_ack", int'(jump_ack), 1);
        chk("s1_busy", int'(busy), 1);
        step(); @(negedge clk);
        chk("s1_y_c2", int'(qbert_y), 10);
        step(); @(negedge clk);
        chk("s1_y_c3", int'(qbert_y), 9);
        wait_done(3, n);
        chk("s1_done_cyc", n, 20);
        chk("s1_x", int'(qbert_x), 13);
        chk("s1_y", int'(qbert_y), 8);
        step(); @(negedge clk);
        chk("s1_busy_end", int'(busy), 0);

        // Down-left jump: x walks first.
        do_load(10, 10);
        chk("s2_load_x", int'(qbert_x), 10);
        jump(2'b11);
        chk("s2_ack", int'(jump_ack), 1);
        wait_done(0, n);
        chk("s2_done", int'(done), 1);
        chk("s2_x", int'(qbert_x), 7);
        chk("s2_y", int'(qbert_y), 12);
        step(); @(negedge clk);
        chk("s2_busy_end", int'(busy), 0);

        // Out-of-bounds: x would go to -2.
        do_load(1, 10);
        jump(2'b01);
        chk("s3_err", int'(jump_err), 1);
        chk("s3_ack", int'(jump_ack), 0);
        chk("s3_busy", int'(busy), 0);
        chk("s3_x", int'(qbert_x), 1);
        chk("s3_y", int'(qbert_y), 10);
        step(); @(negedge clk);
        chk("s3_err_off", int'(jump_err), 0);

        // Second request and load during MOVE1 are ignored.
        jump(2'b00);
        chk("s4_ack", int'(jump_ack), 1);
        step(); @(negedge clk);
        x_init = 11'd15;
        load = 1'b1;
        jump(2'b10);
        load = 1'b0;
        chk("s4_ack2", int'(jump_ack), 0);
        chk("s4_err2", int'(jump_err), 0);
        wait_done(0, n);
        chk("s4_x", int'(qbert_x), 4);
        chk("s4_y", int'(qbert_y), 8);
        step(); @(negedge clk);

        // Reset during MOVE2 abandons the move.
        x_init = 11'd10;
        y_init = 10'd10;
        jump(2'b00);
        n = 0;
        while (qbert_x == 11'd4 && n < 40) begin
            step();
            n++;
            @(negedge clk);
        end
        chk("s5_in_move2", int'(qbert_x), 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("s5_x", int'(qbert_x), 10);
        chk("s5_y", int'(qbert_y), 10);
        chk("s5_busy", int'(busy), 0);
        chk("s5_done", int'(done), 0);
        repeat (8) begin
            step(); @(negedge clk);
        end
        chk("s5_busy_late", int'(busy), 0);

        // Load in IDLE.
        do_load(5, 10);
        chk("s6_x", int'(qbert_x), 5);
        chk("s6_y", int'(qbert_y), 10);

        // Load and jump together: load wins, jump dropped.
        x_init = 11'd6;
        load = 1'b1;
        jump(2'b00);
        load = 1'b0;
        chk("s7_x", int'(qbert_x), 6);
        chk("s7_ack", int'(jump_ack), 0);
        chk("s7_err", int'(jump_err), 0);
        step(); @(negedge clk);
        chk("s7_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
